// File: rtl/logic_pkg.sv
// Shared constants for the logic reduce unit: word-operation codes and FSM states.
package logic_pkg;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_NOR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/bitwise_op.sv
// Combinational bitwise combine of two words under a 2-bit operation code.
module bitwise_op
    import logic_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = '0;
        case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            default: y = ~(a | b);
        endcase
    end

endmodule

// File: rtl/logic_reduce_unit.sv
// Reduces a packet of words with AND/OR/XOR/NOR and reports result, zero flag
// and a saturating beat count through a valid/ready handshake.
module logic_reduce_unit
    import logic_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero,
    output logic [CNT_W-1:0] out_count,
    output logic             out_sat
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic [1:0]       op_q;
    logic [1:0]       op_acc;
    logic [CNT_W-1:0] cnt;
    logic             sat_q;
    logic             accept;

    assign in_ready  = ~rst & (state_q != ST_DONE);
    assign out_valid = (state_q == ST_DONE);
    assign accept    = in_valid & in_ready;

    // NOR accumulates as OR; the inversion is applied once on the result.
    assign op_acc = (op_q == OP_NOR) ? OP_OR : op_q;

    bitwise_op #(.WIDTH(WIDTH)) u_op (
        .a  (acc),
        .b  (in_data),
        .op (op_acc),
        .y  (acc_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_ACCUM: begin
                if (accept) begin
                    state_d = in_last ? ST_DONE : ST_ACCUM;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Accumulator, sampled op, and saturating beat counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc   <= '0;
            op_q  <= OP_AND;
            cnt   <= '0;
            sat_q <= 1'b0;
        end else if (accept) begin
            if (state_q == ST_IDLE) begin
                acc   <= in_data;
                op_q  <= in_op;
                cnt   <= CNT_W'(1);
                sat_q <= 1'b0;
            end else begin
                acc <= acc_next;
                if (cnt == CNT_MAX) begin
                    sat_q <= 1'b1;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

    assign out_data  = (op_q == OP_NOR) ? ~acc : acc;
    assign out_zero  = ~|out_data;
    assign out_count = cnt;
    assign out_sat   = sat_q;

endmodule

// File: tb/tb_logic_reduce_unit.sv
// Self-checking bench for logic_reduce_unit: directed packets plus random
// packets compared against a behavioural reduction model.
module tb_logic_reduce_unit;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_last;
    logic [1:0]  in_op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_zero;
    logic [7:0]  out_count;
    logic        out_sat;

    int errors = 0;
    int checks = 0;
    logic [31:0] beats[$];

    logic_reduce_unit #(.WIDTH(32), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_zero  (out_zero),
        .out_count (out_count),
        .out_sat   (out_sat)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Sends the queued beats as one packet, then checks the result under backpressure.
    task automatic run_packet(input string tag, input logic [1:0] op, input int gapmax, input int bp);
        logic [31:0] res;
        logic [7:0]  ecnt;
        logic        esat;
        int          n;
        int          gaps;
        n   = beats.size();
        res = beats[0];
        for (int i = 1; i < n; i++) begin
            case (op)
                2'b00:   res = res & beats[i];
                2'b10:   res = res ^ beats[i];
                default: res = res | beats[i];
            endcase
        end
        if (op == 2'b11) res = ~res;
        ecnt = (n > 255) ? 8'd255 : 8'(n);
        esat = (n > 255);

        for (int i = 0; i < n; i++) begin
            gaps = (gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0;
            for (int g = 0; g < gaps; g++) begin
                @(negedge clk);
                in_valid = 1'b0;
                in_data  = $urandom;
                in_op    = 2'($urandom);
                in_last  = 1'($urandom);
            end
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = beats[i];
            in_last  = (i == n - 1);
            in_op    = (i == 0) ? op : 2'($urandom);
            check({tag, " in_ready"}, 64'(in_ready), 64'(1'b1));
            check({tag, " no early out_valid"}, 64'(out_valid), 64'(1'b0));
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        check({tag, " out_valid latency"}, 64'(out_valid), 64'(1'b1));

        for (int k = 0; k < bp; k++) begin
            in_valid  = 1'b1;
            in_data   = $urandom;
            in_op     = 2'($urandom);
            in_last   = 1'b1;
            out_ready = 1'b0;
            check({tag, " hold out_valid"}, 64'(out_valid), 64'(1'b1));
            check({tag, " hold in_ready"}, 64'(in_ready), 64'(1'b0));
            check({tag, " hold out_data"}, 64'(out_data), 64'(res));
            check({tag, " hold out_count"}, 64'(out_count), 64'(ecnt));
            @(negedge clk);
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        check({tag, " out_valid"}, 64'(out_valid), 64'(1'b1));
        check({tag, " out_data"}, 64'(out_data), 64'(res));
        check({tag, " out_zero"}, 64'(out_zero), 64'(res == 32'd0));
        check({tag, " out_count"}, 64'(out_count), 64'(ecnt));
        check({tag, " out_sat"}, 64'(out_sat), 64'(esat));
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, " out_valid drop"}, 64'(out_valid), 64'(1'b0));
        check({tag, " in_ready back"}, 64'(in_ready), 64'(1'b1));
        beats.delete();
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        in_op     = 2'b00;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("reset in_ready", 64'(in_ready), 64'(1'b0));
        check("reset out_valid", 64'(out_valid), 64'(1'b0));
        check("reset out_data", 64'(out_data), 64'(32'd0));
        check("reset out_zero", 64'(out_zero), 64'(1'b1));
        check("reset out_count", 64'(out_count), 64'(8'd0));
        check("reset out_sat", 64'(out_sat), 64'(1'b0));
        rst = 1'b0;
        #1;
        check("post-reset in_ready", 64'(in_ready), 64'(1'b1));

        beats.push_back(32'h007fa509);
        run_packet("single or", 2'b01, 0, 0);

        beats.push_back(32'hffffffff);
        beats.push_back(32'h0000ffff);
        beats.push_back(32'h00ff00ff);
        run_packet("xor3", 2'b10, 1, 1);

        beats.push_back(32'h00000000);
        beats.push_back(32'h00000000);
        run_packet("nor2", 2'b11, 0, 0);

        beats.push_back(32'hffff0000);
        beats.push_back(32'h0000ffff);
        run_packet("and2", 2'b00, 0, 0);

        for (int i = 0; i < 4; i++) beats.push_back($urandom);
        run_packet("backpressure", 2'b10, 2, 5);

        for (int i = 0; i < 300; i++) beats.push_back(32'h1);
        run_packet("saturate", 2'b01, 0, 0);

        beats.push_back(32'h12345678);
        run_packet("sat clear", 2'b00, 0, 0);

        // Abort a packet after two beats with an asynchronous reset.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = $urandom;
            in_last  = 1'b0;
            in_op    = 2'b01;
        end
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("midreset in_ready", 64'(in_ready), 64'(1'b0));
        check("midreset out_valid", 64'(out_valid), 64'(1'b0));
        check("midreset out_data", 64'(out_data), 64'(32'd0));
        check("midreset out_count", 64'(out_count), 64'(8'd0));
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("after midreset in_ready", 64'(in_ready), 64'(1'b1));
        check("after midreset out_valid", 64'(out_valid), 64'(1'b0));
        beats.push_back(32'ha5a5a5a5);
        run_packet("after reset and", 2'b00, 0, 0);

        for (int p = 0; p < 40; p++) begin
            int len;
            len = int'($urandom_range(8, 1));
            for (int i = 0; i < len; i++) beats.push_back($urandom);
            run_packet("random", 2'($urandom), 2, int'($urandom_range(3, 0)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
